// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared types and constants for the multiply/divide unit
package mult_div_unit_pkg;
  localparam int W = 32;
  localparam int ITERS = 32;
  localparam int CW = $clog2(ITERS);
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction
endpackage

// File: rtl/mult_div_unit_div_step.sv
// mult_div_unit_div_step: one restoring-division iteration on unsigned magnitudes
module mult_div_unit_div_step
  import mult_div_unit_pkg::*;
(
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvs,
  input  logic         bit_in,
  output logic [W-1:0] rem_next,
  output logic         q
);
  logic [W:0] sh;
  logic [W+1:0] diff;
  // shift in the next dividend bit, keep the trial subtraction only if it stays non-negative
  always_comb begin
    sh = {rem, bit_in};
    diff = {1'b0, sh} - {2'b0, dvs};
    q = ~diff[W+1];
    rem_next = q ? diff[W-1:0] : sh[W-1:0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiply and restoring divide, 32 cycles per op
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         MDCtrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [W:0] ra, bsum;
  logic [W-1:0] rq, rm, rem_next, quo;
  logic rx, neg_q, neg_r, qb;

  mult_div_unit_div_step div_step (
    .rem(ra[W-1:0]),
    .dvs(rm),
    .bit_in(rq[W-1]),
    .rem_next(rem_next),
    .q(qb)
  );

  // Booth add/subtract of the multiplicand; 33-bit accumulator absorbs the -2^31 case
  always_comb begin
    bsum = (rq[0] & ~rx) ? ra - {rm[W-1], rm} : (~rq[0] & rx) ? ra + {rm[W-1], rm} : ra;
    quo = {rq[W-2:0], qb};
  end

  // next state; a zero divisor skips straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = !start ? IDLE : MDCtrl == MD_MULT ? MULT : b == '0 ? DONE : DIV;
      MULT, DIV: state_next = cnt == '0 ? DONE : state;
      DONE:      state_next = IDLE;
    endcase
  end

  // state register and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      state <= state_next;
      busy <= state_next == MULT || state_next == DIV;
      done <= state_next == DONE;
      div0 <= state == IDLE && state_next == DONE;
    end
  end

  // operand latch, iteration datapath, and result update on the final iteration only
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      ra <= '0;
      rq <= '0;
      rm <= '0;
      rx <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= CW'(ITERS - 1);
      ra <= '0;
      rx <= 1'b0;
      rq <= MDCtrl == MD_MULT ? a : mag(a);
      rm <= MDCtrl == MD_MULT ? b : mag(b);
      neg_q <= a[W-1] ^ b[W-1];
      neg_r <= a[W-1];
    end else if (state == MULT) begin
      cnt <= cnt - CW'(1);
      ra <= {bsum[W], bsum[W:1]};
      rq <= {bsum[0], rq[W-1:1]};
      rx <= rq[0];
      if (cnt == '0) begin
        hi <= bsum[W:1];
        lo <= {bsum[0], rq[W-1:1]};
      end
    end else if (state == DIV) begin
      cnt <= cnt - CW'(1);
      ra <= {1'b0, rem_next};
      rq <= quo;
      if (cnt == '0) begin
        hi <= neg_r ? -rem_next : rem_next;
        lo <= neg_q ? -quo : quo;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset, start, MDCtrl, busy, done, div0;
  logic [31:0] a, b, hi, lo;
  logic [63:0] mres = '0;
  int n_chk = 0, n_err = 0;
  logic md;
  logic [31:0] x, y;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .MDCtrl(MDCtrl), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {hi,lo} from plain signed arithmetic; a zero divisor leaves the previous result
  function automatic logic [63:0] model(input logic m, input logic [31:0] p, input logic [31:0] q, input logic [63:0] prev);
    longint sp, sq, qu, re;
    sp = longint'($signed(p));
    sq = longint'($signed(q));
    if (m == 1'b0) return sp * sq;
    if (q == 0) return prev;
    qu = sp / sq;
    re = sp % sq;
    return {re[31:0], qu[31:0]};
  endfunction

  task automatic run_op(input logic m, input logic [31:0] p, input logic [31:0] q, input bit poke);
    logic [63:0] exp, res;
    int done_k, busy_n, hold_bad, div0_bad;
    logic d0;
    bit z;
    done_k = 0; busy_n = 0; hold_bad = 0; div0_bad = 0; d0 = 1'b0; res = '0;
    z = m == 1'b1 && q == 0;
    exp = model(m, p, q, mres);
    @(posedge clk); #1;
    start = 1'b1; MDCtrl = m; a = p; b = q;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; MDCtrl = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clk);
      if (poke && k == 5) begin start = 1'b1; MDCtrl = ~m; a = $urandom; b = 32'd0; end
      if (poke && k == 6) start = 1'b0;
      busy_n += int'(busy);
      if (done) begin
        done_k = k;
        res = {hi, lo};
        d0 = div0;
      end else begin
        if ({hi, lo} !== mres) hold_bad++;
        if (div0) div0_bad++;
      end
    end
    chk("done_cycle", 64'(done_k), z ? 64'd1 : 64'd33);
    chk("busy_cycles", 64'(busy_n), z ? 64'd0 : 64'd32);
    chk("hilo_hold", 64'(hold_bad), 64'd0);
    chk("div0_quiet", 64'(div0_bad), 64'd0);
    chk("div0", 64'(d0), 64'(z));
    chk("hi", 64'(res[63:32]), 64'(exp[63:32]));
    chk("lo", 64'(res[31:0]), 64'(exp[31:0]));
    mres = exp;
    if (poke) repeat (3) begin
      @(negedge clk);
      chk("no_queue", 64'({busy, done}), 64'd0);
    end
  endtask

  task automatic reset_mid();
    int done_n;
    done_n = 0;
    @(posedge clk); #1;
    start = 1'b1; MDCtrl = 1'b0; a = $urandom | 32'h100; b = $urandom | 32'h100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      done_n += int'(done);
    end
    chk("busy_before_rst", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    mres = '0;
    repeat (40) begin
      @(negedge clk);
      done_n += int'(done);
    end
    chk("rst_mid_no_done", 64'(done_n), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDCtrl = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", 64'({busy, done, div0}), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0);
    chk("mult_7x-3", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0);
    chk("mult_min_sq", {hi, lo}, 64'h40000000_00000000);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_-7by2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(1'b1, 32'h451, 32'h20, 1'b0);
    chk("div_prior", {hi, lo}, 64'h00000011_00000022);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_min_by_-1", {hi, lo}, 64'h00000000_80000000);
    run_op(1'b0, 32'd12345, 32'hFFFFFF9D, 1'b1);
    reset_mid();
    for (int i = 0; i < 24; i++) begin
      md = 1'($urandom_range(0, 1));
      x = $urandom_range(0, 3) == 0 ? $urandom_range(0, 100) : $urandom;
      y = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 1) == 0 ? $urandom_range(1, 20) : $urandom;
      if ($urandom_range(0, 1) == 0) y = -y;
      run_op(md, x, y, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port MDCtrl, input, 1 bit: 0 = signed multiply (MULT), 1 = signed divide (DIV).
REQ-005 SHALL have port a, input, 32 bits: rs operand (multiplicand or dividend).
REQ-006 SHALL have port b, input, 32 bits: rt operand (multiplier or divisor).
REQ-007 SHALL have port busy, output, 1 bit: high while iterating.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse; hi/lo are valid and the datapath may assert HILOWrite.
REQ-009 SHALL have port div0, output, 1 bit: divide-by-zero flag, coincident with done.
REQ-010 SHALL have port hi, output, 32 bits: product[63:32] or remainder.
REQ-011 SHALL have port lo, output, 32 bits: product[31:0] or quotient.

Function
REQ-012 SHALL implement the FSM states IDLE, MULT, DIV and DONE.
REQ-013 SHALL use these transitions: IDLE->MULT|DIV on start per MDCtrl; MULT/DIV->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-014 SHALL latch a, b and MDCtrl on the edge that accepts start; later operand changes SHALL have no effect.
REQ-015 SHALL iterate with a 5-bit counter loaded with 31 and decremented once per iteration cycle; the counter is 0 on the last iteration.
REQ-016 SHALL assert done (and update hi/lo) in cycle N+33 when start is sampled high in cycle N in IDLE.
REQ-017 SHALL hold busy high in cycles N+1..N+32, and low in IDLE and DONE.
REQ-018 SHALL implement MULT as radix-2 Booth on 32-bit two's-complement operands, producing the exact 64-bit signed product.
REQ-019 SHALL implement DIV as 32-step restoring division on operand magnitudes, followed by sign fix-up.
REQ-020 SHALL make the DIV quotient truncate toward zero, with the remainder taking the dividend's sign.
REQ-021 SHALL produce lo=0x80000000, hi=0 for 0x80000000 / 0xFFFFFFFF; no overflow flag exists.
REQ-022 SHALL, for DIV with b==0, perform no iterations: IDLE->DONE directly, done and div0 high in cycle N+1, hi/lo unchanged.
REQ-023 SHALL assert div0 only in a DONE cycle of a divide-by-zero; div0 is 0 in all other cycles.
REQ-024 SHALL ignore start while in MULT, DIV or DONE, with no queuing.
REQ-025 SHALL hold hi/lo stable between DONE cycles, so intermediate iteration values are never visible on hi/lo.
REQ-026 SHALL, when start is high again in the cycle after DONE (IDLE), accept it normally; back-to-back operations are separated by exactly one IDLE cycle.

Reset
REQ-027 SHALL make reset take priority over all other inputs.
REQ-028 SHALL, on reset, set state=IDLE, counter=0, busy=0, done=0, div0=0, hi=0, lo=0.
REQ-029 SHALL, on reset mid-operation, abandon the operation: no done pulse, and busy is 0 in the cycle after the reset edge.

Structure
REQ-030 SHALL place the following in a shared package: the state enum (IDLE, MULT, DIV, DONE), the MDCtrl encodings (MD_MULT=0, MD_DIV=1), data width 32 and iteration count 32.
REQ-031 SHALL use one combinational sub-module, div_step, for a single restoring-division iteration (partial remainder, divisor -> next remainder, quotient bit); the Booth step SHALL stay inline.
REQ-032 SHALL use registered outputs only; there SHALL be no combinational path from inputs to busy, done or div0.

Verification
REQ-033 SHALL verify MULT 7 * 0xFFFFFFFD (-3), start in cycle N -> done in N+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB, and busy high for exactly 32 cycles.
REQ-034 SHALL verify MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 SHALL verify DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done in N+33, div0=0.
REQ-036 SHALL verify DIV 5 / 0 after a prior result of hi=0x11, lo=0x22 -> done=div0=1 in N+1, hi=0x11, lo=0x22 retained.
REQ-037 SHALL verify DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 SHALL verify that a start pulse in iteration cycle 5 is ignored and that reset asserted in iteration cycle 10 -> busy=0 and hi=lo=0 next cycle, with no done pulse.
